// File: rtl/mult_pkg.sv
// Shared types and helpers for the shared sequential multiplier arbiter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_REQ       = 8;

  // Onehot of the first set bit at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] valid,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
    logic [MAX_REQ-1:0] oh;
    logic               found;
    logic [2:0]         idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/mult_engine_sa.sv
// Shift-add unsigned multiplier: loads on start, done pulses in the WIDTH-th cycle
// with the product presented combinationally from the final iteration.
module mult_engine_sa
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_d;
  logic [WIDTH-1:0] a_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [WIDTH:0]   upper;

  // Upper half carries one extra bit so the add never overflows before the shift.
  always_comb begin
    upper   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_d   = {upper, acc_q[WIDTH-1:0]} >> 1;
    done    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    product = acc_d[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      acc_q <= {{(WIDTH+1){1'b0}}, b};
      a_q   <= a;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one mult_engine_sa among NUM_REQ requesters,
// with a single tagged, backpressured response channel.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     busy
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [2*WIDTH-1:0] rsp_product_q;

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] grant_full;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    grant_next;
  logic               handshake;
  logic               eng_done;
  logic [2*WIDTH-1:0] eng_product;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
    grant_full               = rr_onehot(valid_ext, 3'(rr_ptr_q), NUM_REQ);
    grant_oh                 = grant_full[NUM_REQ-1:0];
    grant_id                 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_id = ID_W'(i);
    end
    grant_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    // Gate with rst_n so nothing is offered while reset is held.
    handshake  = (state_q == IDLE) && rst_n && (|grant_oh);
  end

  mult_engine_sa #(.WIDTH(WIDTH)) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (handshake),
    .a       (a_arr[grant_id]),
    .b       (b_arr[grant_id]),
    .done    (eng_done),
    .product (eng_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        id_q     <= grant_id;
        rr_ptr_q <= grant_next;
      end
      if (state_q == RUN && eng_done) begin
        rsp_id_q      <= id_q;
        rsp_product_q <= eng_product;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = RUN;
      RUN:     if (eng_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = ((state_q == IDLE) && rst_n) ? grant_oh : '0;
    rsp_valid   = (state_q == RESP);
    busy        = (state_q == RUN) || (state_q == RESP);
    rsp_id      = rsp_id_q;
    rsp_product = rsp_product_q;
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with an in-order response scoreboard.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [7:0]               rsp_product;
  logic                     busy;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard sampled at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_unexpected: observed id %0d product %0d expected no response", rsp_id, rsp_product);
      end else begin
        e = sb.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_product", 32'(rsp_product), 32'(e.prod));
        $display("rsp id=%0d product=%0d at cycle %0d", rsp_id, rsp_product, cyc);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = 4'(a);
    req_b[i*WIDTH +: WIDTH] = 4'(b);
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_t e;
    e.id   = 2'(id);
    e.prod = 8'(a * b);
    sb.push_back(e);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (req_ready == '0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc_cyc;
    int prev_cyc;
    int pa[4];
    int pb[4];
    int ids[5];
    int ca[4];
    int cb[4];

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    acc_cyc   = 0;
    prev_cyc  = 0;

    // Reset state, with all requests asserted
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_product", 32'(rsp_product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // 1: single request 3*5
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'b0001);
    push_exp(0, 3, 5);
    acc_cyc = cyc;
    tick();
    req_valid = '0;
    chk("t1_busy_run", 32'(busy), 32'd1);
    chk("t1_ready_run", 32'(req_ready), 32'd0);
    wait_rsp();
    chk("t1_latency", 32'(cyc - acc_cyc), 32'd5);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_product", 32'(rsp_product), 32'd15);
    tick();
    chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 3: corner operands through requester 1
    ca = '{0, 15, 1, 15};
    cb = '{9, 15, 15, 1};
    for (int k = 0; k < 4; k++) begin
      set_op(1, ca[k], cb[k]);
      req_valid = 4'b0010;
      #1;
      wait_grant();
      chk("t3_req_ready", 32'(req_ready), 32'b0010);
      push_exp(1, ca[k], cb[k]);
      $display("req id=1 a=%0d b=%0d at cycle %0d", ca[k], cb[k], cyc);
      tick();
      req_valid = '0;
      drain("t3_drain");
    end

    // 4: backpressure on requester 3
    rsp_ready = 1'b0;
    set_op(3, 6, 7);
    req_valid = 4'b1000;
    #1;
    wait_grant();
    chk("t4_req_ready", 32'(req_ready), 32'b1000);
    push_exp(3, 6, 7);
    tick();
    req_valid = 4'b0111;
    wait_rsp();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_id", 32'(rsp_id), 32'd3);
      chk("t4_hold_product", 32'(rsp_product), 32'd42);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("t4_release_valid", 32'(rsp_valid), 32'd0);
    chk("t4_release_busy", 32'(busy), 32'd0);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 6: requester 2 raises valid while busy, then withdraws
    set_op(0, 2, 3);
    set_op(2, 5, 5);
    req_valid = 4'b0001;
    #1;
    wait_grant();
    chk("t6_req_ready", 32'(req_ready), 32'b0001);
    push_exp(0, 2, 3);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("t6_withdrawn_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = '0;
    drain("t6_drain");
    for (int k = 0; k < 12; k++) tick();
    chk("t6_no_extra_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    // 5: reset two cycles into RUN
    set_op(1, 5, 6);
    req_valid = 4'b0010;
    #1;
    wait_grant();
    chk("t5_req_ready", 32'(req_ready), 32'b0010);
    tick();
    tick();
    req_valid = '0;
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_id", 32'(rsp_id), 32'd0);
    chk("t5_rst_product", 32'(rsp_product), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);

    // 2: all four requesters, grants 0,1,2,3,0 from a fresh pointer
    pa  = '{2, 15, 9, 11};
    pb  = '{7, 15, 0, 13};
    ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_op(i, pa[i], pb[i]);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      chk("t2_grant", 32'(req_ready), 32'd1 << ids[k]);
      if (k > 0) chk("t2_spacing", 32'(cyc - prev_cyc), 32'd6);
      prev_cyc = cyc;
      push_exp(ids[k], pa[ids[k]], pb[ids[k]]);
      $display("req id=%0d a=%0d b=%0d at cycle %0d", ids[k], pa[ids[k]], pb[ids[k]], cyc);
      tick();
    end
    req_valid = '0;
    drain("t2_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
